poly_song_reader: RTL and testbench
===================================

Name: poly_song_reader

Overview:
- Parametrised successor to the three-voice song reader: walks a song ROM and dispatches notes to NUM_VOICES independent note players.
- Tracks per-voice busy state from note_done and stalls on busy voices.
- Supports beat-timed advance/rest entries, pause/resume, song switching mid-play and a one-cycle song_done pulse.
- Sits between the song ROM, beat generator and the bank of note players in the music player top level.

Parameters:
NUM_VOICES, 3, number of note-player channels (1..2^VOICE_SEL_W)
VOICE_SEL_W, 2, width of voice-select field in a ROM entry
NOTE_W, 6, note field width
DUR_W, 6, duration field width
SONG_W, 2, song-select width
ENTRY_ADDR_W, 5, entries per song = 2^ENTRY_ADDR_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  1 = run, 0 = pause (state frozen)
song  in  SONG_W  song select
beat  in  1  one-cycle beat tick
note_done  in  NUM_VOICES  per-voice completion pulse from note players
rom_addr  out  SONG_W+ENTRY_ADDR_W  {song_latched, entry_idx}, registered
rom_data  in  1+VOICE_SEL_W+NOTE_W+DUR_W  {advance, voice_sel, note, duration}, valid one cycle after rom_addr changes
note_out  out  NUM_VOICES*NOTE_W  voice v note at [v*NOTE_W +: NOTE_W], registered
duration_out  out  NUM_VOICES*DUR_W  voice v duration, same packing
new_note  out  NUM_VOICES  one-cycle pulse per voice when note_out/duration_out load
song_done  out  1  one-cycle pulse at end of song

Behaviour:
- Reset: state IDLE; entry_idx, song_latched, rom_addr, note_out, duration_out, new_note, song_done, busy[] and beat counter all 0. Reset overrides everything, mid-operation included.
- busy[v]: set on the cycle new_note[v] is issued, cleared on note_done[v]. If both occur in the same cycle, busy stays 1.
- FSM states: IDLE, FETCH, DECODE, WAIT_VOICE, WAIT_BEATS, DONE.
- IDLE: entry_idx=0. On play=1: latch song, go to FETCH.
- FETCH: one cycle for ROM latency, then DECODE.
- DECODE samples rom_data and latches it as the current entry:
  - advance=1, duration=0: end marker, go to DONE.
  - advance=1, duration>0: load beat counter=duration, go to WAIT_BEATS.
  - advance=0, voice_sel>=NUM_VOICES: no-op, advance index.
  - advance=0, busy[voice_sel]=0: issue, advance index.
  - advance=0, busy[voice_sel]=1: go to WAIT_VOICE.
- Issue: at the clock edge, load note_out/duration_out slice v from the entry and pulse new_note[v] for exactly one cycle. Other voices' slices are unchanged.
- Back-to-back free-voice notes issue every 2 cycles. The first new_note appears at edge 3 after the cycle play is sampled high in IDLE.
- WAIT_VOICE: in the cycle busy[v]==0 (note_done already registered), issue and advance index. No timeout.
- WAIT_BEATS: each beat with play=1 decrements the counter. The beat that takes it 1->0 advances the index.
- Advance index: if entry_idx==2^ENTRY_ADDR_W-1, go to DONE (wrap = end of song). Otherwise entry_idx+1 and FETCH.
- DONE: song_done=1 for the single cycle after entering. State holds until play=0, then IDLE. No new_note in DONE.
- play=0 in any non-IDLE state: all registers frozen, beats ignored, no issue, note_done still clears busy. Resume continues exactly where it stopped.
- Song change: in any non-IDLE, non-DONE state, song != song_latched with play=1 does the following next cycle:
  - entry_idx=0, song_latched=song, busy[] cleared, state FETCH;
  - no song_done, no new_note that cycle.
- All arithmetic unsigned; duration passed through unmodified.

Test Plan:
- Reset: reset=1 for 2 cycles with play=1, beat toggling -> all outputs 0, rom_addr=0, no new_note; first rom_addr change only after reset drops.
- Song 0 ROM {v0,n12,d8},{v1,n20,d4},{adv,d2},{adv,d0}, play=1 ->
  - new_note[0] at edge 3 with note_out[5:0]=12, duration_out[5:0]=8;
  - new_note[1] 2 cycles later with note 20, dur 4;
  - next fetch only after 2nd beat;
  - song_done single pulse 2 cycles later.
- Busy stall: entries {v2,n30},{v2,n31}, note_done=0 -> one new_note[2] (note 30), then stall. Pulse note_done[2] at cycle T -> new_note[2] with note 31 at edge T+1. note_done[2] coincident with that issue leaves busy[2]=1.
- Pause: {adv,d3}; one beat, play=0, 5 beats, play=1 -> exactly 2 more beats required before next fetch; rom_addr constant during pause.
- Song switch: song 0->2 during WAIT_BEATS -> rom_addr={2,0} within 1 cycle, busy all 0, song_done never asserted, song 2 notes then dispatched normally.
- Wrap/invalid voice: song 1 holds 32 entries {voice_sel=3,...}, no end marker -> zero new_note, song_done once after index 31 (64 cycles after FETCH of entry 0), then stays DONE until play=0.

Source files
------------

// File: rtl/poly_song_reader.sv
// Song ROM walker that dispatches notes to NUM_VOICES note players,
// stalling on busy voices and timing rests/advances from the beat tick.
module poly_song_reader #(
    parameter int NUM_VOICES   = 3,
    parameter int VOICE_SEL_W  = 2,
    parameter int NOTE_W       = 6,
    parameter int DUR_W        = 6,
    parameter int SONG_W       = 2,
    parameter int ENTRY_ADDR_W = 5
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_play,
    input  logic [SONG_W-1:0]                      i_song,
    input  logic                                   i_beat,
    input  logic [NUM_VOICES-1:0]                  i_note_done,
    output logic [SONG_W+ENTRY_ADDR_W-1:0]         o_rom_addr,
    input  logic [VOICE_SEL_W+NOTE_W+DUR_W:0]      i_rom_data,
    output logic [NUM_VOICES*NOTE_W-1:0]           o_note_out,
    output logic [NUM_VOICES*DUR_W-1:0]            o_duration_out,
    output logic [NUM_VOICES-1:0]                  o_new_note,
    output logic                                   o_song_done
);

    localparam int ENTRY_W = 1 + VOICE_SEL_W + NOTE_W + DUR_W;
    localparam int SLOTS   = 1 << VOICE_SEL_W;
    localparam logic [ENTRY_ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WAIT_VOICE,
        S_WAIT_BEATS,
        S_DONE
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [ENTRY_ADDR_W-1:0]       r_idx;
    logic [SONG_W-1:0]             r_song;
    logic [DUR_W-1:0]              r_cnt;
    logic [NUM_VOICES-1:0]         r_busy;
    logic [NUM_VOICES*NOTE_W-1:0]  r_note;
    logic [NUM_VOICES*DUR_W-1:0]   r_dur;
    logic [NUM_VOICES-1:0]         r_new_note;
    logic                          r_song_done;
    logic [ENTRY_W-1:0]            r_cur;

    logic [ENTRY_W-1:0]            w_ent;
    logic                          w_adv;
    logic [VOICE_SEL_W-1:0]        w_vsel;
    logic [NOTE_W-1:0]             w_note;
    logic [DUR_W-1:0]              w_dur;
    logic                          w_vvalid;
    logic [SLOTS-1:0]              w_busy_ext;
    logic                          w_vbusy;
    logic                          w_active;
    logic                          w_issue;
    logic                          w_step;
    logic                          w_switch;
    logic                          w_load;
    logic                          w_dec;
    logic [NUM_VOICES-1:0]         w_issue_mask;

    // DECODE works on live ROM data; WAIT_VOICE replays the latched entry
    assign w_ent      = (r_state == S_DECODE) ? i_rom_data : r_cur;
    assign w_adv      = w_ent[ENTRY_W-1];
    assign w_vsel     = w_ent[ENTRY_W-2 -: VOICE_SEL_W];
    assign w_note     = w_ent[DUR_W +: NOTE_W];
    assign w_dur      = w_ent[DUR_W-1:0];
    assign w_vvalid   = {1'b0, w_vsel} < (VOICE_SEL_W+1)'(NUM_VOICES);
    assign w_busy_ext = SLOTS'(r_busy);
    assign w_vbusy    = w_busy_ext[w_vsel];
    assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);

    always_comb begin
        w_next   = r_state;
        w_issue  = 1'b0;
        w_step   = 1'b0;
        w_switch = 1'b0;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        if (w_active && i_play && (i_song != r_song)) begin
            w_switch = 1'b1;
            w_next   = S_FETCH;
        end else begin
            case (r_state)
                S_IDLE:  if (i_play) w_next = S_FETCH;
                S_FETCH: if (i_play) w_next = S_DECODE;
                S_DECODE: begin
                    if (i_play) begin
                        if (w_adv) begin
                            if (w_dur == '0) begin
                                w_next = S_DONE;
                            end else begin
                                w_load = 1'b1;
                                w_next = S_WAIT_BEATS;
                            end
                        end else if (!w_vvalid) begin
                            w_step = 1'b1;
                        end else if (!w_vbusy) begin
                            w_issue = 1'b1;
                            w_step  = 1'b1;
                        end else begin
                            w_next = S_WAIT_VOICE;
                        end
                    end
                end
                S_WAIT_VOICE: begin
                    if (i_play && !w_vbusy) begin
                        w_issue = 1'b1;
                        w_step  = 1'b1;
                    end
                end
                S_WAIT_BEATS: begin
                    if (i_play && i_beat) begin
                        w_dec  = (r_cnt != '0);
                        w_step = (r_cnt <= DUR_W'(1));
                    end
                end
                S_DONE:  if (!i_play) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
            if (w_step) w_next = (r_idx == LAST_IDX) ? S_DONE : S_FETCH;
        end
    end

    always_comb begin
        w_issue_mask = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_issue_mask[v] = w_issue && (w_vsel == VOICE_SEL_W'(v));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_song      <= '0;
            r_cnt       <= '0;
            r_busy      <= '0;
            r_note      <= '0;
            r_dur       <= '0;
            r_new_note  <= '0;
            r_song_done <= 1'b0;
            r_cur       <= '0;
        end else begin
            r_state     <= w_next;
            r_new_note  <= w_issue_mask;
            r_song_done <= (w_next == S_DONE) && (r_state != S_DONE);
            // a same-cycle issue wins over the completion pulse
            r_busy <= w_switch ? '0 : ((r_busy & ~i_note_done) | w_issue_mask);
            if (r_state == S_IDLE) begin
                r_idx <= '0;
                if (i_play) r_song <= i_song;
            end else if (w_switch) begin
                r_idx  <= '0;
                r_song <= i_song;
            end else if (w_step && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + ENTRY_ADDR_W'(1);
            end
            if (w_load) begin
                r_cnt <= w_dur;
            end else if (w_dec) begin
                r_cnt <= r_cnt - DUR_W'(1);
            end
            if ((r_state == S_DECODE) && i_play) r_cur <= i_rom_data;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_issue_mask[v]) begin
                    r_note[v*NOTE_W +: NOTE_W] <= w_note;
                    r_dur[v*DUR_W +: DUR_W]    <= w_dur;
                end
            end
        end
    end

    assign o_rom_addr     = {r_song, r_idx};
    assign o_note_out     = r_note;
    assign o_duration_out = r_dur;
    assign o_new_note     = r_new_note;
    assign o_song_done    = r_song_done;

endmodule

// File: tb/tb_poly_song_reader.sv
// Directed bench for poly_song_reader: a registered ROM model plus
// hand-timed scenarios checked at the falling edge.
module tb_poly_song_reader;

    logic        clk = 1'b0;
    logic        rst, play, beat;
    logic [1:0]  song;
    logic [2:0]  nd;
    logic [6:0]  rom_addr;
    logic [14:0] rom_data;
    logic [17:0] note_out, dur_out;
    logic [2:0]  new_note;
    logic        song_done;
    logic [14:0] rom [128];
    int          n_cmp = 0;
    int          n_bad = 0;

    poly_song_reader dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_play         (play),
        .i_song         (song),
        .i_beat         (beat),
        .i_note_done    (nd),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_data),
        .o_note_out     (note_out),
        .o_duration_out (dur_out),
        .o_new_note     (new_note),
        .o_song_done    (song_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [14:0] ent(input int a, input int v, input int n, input int d);
        return {a[0], 2'(v), 6'(n), 6'(d)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = ent(1, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; play = 1'b0; beat = 1'b0; nd = '0; song = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic pulse_beat();
        beat = 1'b1; step();
        beat = 1'b0; step();
    endtask

    task automatic test_reset();
        clear_rom();
        song = 2'd3; play = 1'b1; nd = '0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            beat = (i == 0);
            step();
            n_cmp++;
            if ({rom_addr, new_note, song_done, note_out, dur_out} !== '0) begin
                n_bad++;
                $display("FAIL reset_outs: got addr=%0d nn=%b sd=%b note=%h dur=%h want all 0",
                         rom_addr, new_note, song_done, note_out, dur_out);
            end
        end
        rst = 1'b0; beat = 1'b0;
        step();
        n_cmp++;
        if (rom_addr !== 7'd96) begin
            n_bad++; $display("FAIL reset_first_addr: got %0d want 96", rom_addr);
        end
        step(); step();
        n_cmp++;
        if (song_done !== 1'b1) begin
            n_bad++; $display("FAIL reset_end_marker: got %b want 1", song_done);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({rom_addr, song_done, new_note} !== '0) begin
            n_bad++;
            $display("FAIL reset_midop: got addr=%0d sd=%b nn=%b want 0", rom_addr, song_done, new_note);
        end
        rst = 1'b0; play = 1'b0;
        step();
    endtask

    task automatic test_basic();
        do_reset(); clear_rom();
        rom[0] = ent(0, 0, 12, 8);
        rom[1] = ent(0, 1, 20, 4);
        rom[2] = ent(1, 0, 0, 2);
        rom[3] = ent(1, 0, 0, 0);
        song = 2'd0; play = 1'b1;
        step(); step();
        n_cmp++;
        if (new_note !== 3'b000) begin
            n_bad++; $display("FAIL basic_early: got %b want 000", new_note);
        end
        step();
        n_cmp++;
        if ({new_note, note_out[5:0], dur_out[5:0]} !== {3'b001, 6'd12, 6'd8}) begin
            n_bad++;
            $display("FAIL basic_v0: got nn=%b note=%0d dur=%0d want 001/12/8",
                     new_note, note_out[5:0], dur_out[5:0]);
        end
        step(); step();
        n_cmp++;
        if ({new_note, note_out[11:0], dur_out[11:0]} !== {3'b010, 6'd20, 6'd12, 6'd4, 6'd8}) begin
            n_bad++;
            $display("FAIL basic_v1: got nn=%b note=%h dur=%h want 010/20,12/4,8",
                     new_note, note_out[11:0], dur_out[11:0]);
        end
        step(); step();
        n_cmp++;
        if (rom_addr !== 7'd2) begin
            n_bad++; $display("FAIL basic_rest_addr: got %0d want 2", rom_addr);
        end
        pulse_beat();
        n_cmp++;
        if (rom_addr !== 7'd2) begin
            n_bad++; $display("FAIL basic_one_beat: got %0d want 2", rom_addr);
        end
        beat = 1'b1; step(); beat = 1'b0;
        n_cmp++;
        if ({rom_addr, song_done} !== {7'd3, 1'b0}) begin
            n_bad++; $display("FAIL basic_two_beats: got addr=%0d sd=%b want 3/0", rom_addr, song_done);
        end
        step(); step();
        n_cmp++;
        if (song_done !== 1'b1) begin
            n_bad++; $display("FAIL basic_done: got %b want 1", song_done);
        end
        step();
        n_cmp++;
        if (song_done !== 1'b0) begin
            n_bad++; $display("FAIL basic_done_pulse: got %b want 0", song_done);
        end
    endtask

    task automatic test_busy_stall();
        int hits;
        do_reset(); clear_rom();
        rom[0] = ent(0, 2, 30, 5);
        rom[1] = ent(0, 2, 31, 6);
        rom[2] = ent(0, 2, 32, 7);
        rom[3] = ent(1, 0, 0, 0);
        song = 2'd0; play = 1'b1;
        step(); step(); step();
        n_cmp++;
        if ({new_note, note_out[17:12]} !== {3'b100, 6'd30}) begin
            n_bad++; $display("FAIL busy_first: got nn=%b note=%0d want 100/30", new_note, note_out[17:12]);
        end
        hits = 0;
        for (int e = 4; e <= 10; e++) begin
            step();
            if (new_note !== 3'b000) hits++;
        end
        n_cmp++;
        if (hits != 0) begin
            n_bad++; $display("FAIL busy_stall: got %0d issues want 0", hits);
        end
        nd = 3'b100;
        step();
        n_cmp++;
        if (new_note !== 3'b000) begin
            n_bad++; $display("FAIL busy_release_lat: got %b want 000", new_note);
        end
        step();
        n_cmp++;
        if ({new_note, note_out[17:12], dur_out[17:12]} !== {3'b100, 6'd31, 6'd6}) begin
            n_bad++;
            $display("FAIL busy_release: got nn=%b note=%0d dur=%0d want 100/31/6",
                     new_note, note_out[17:12], dur_out[17:12]);
        end
        nd = 3'b000;
        hits = 0;
        for (int e = 13; e <= 16; e++) begin
            step();
            if (new_note !== 3'b000) hits++;
        end
        n_cmp++;
        if (hits != 0) begin
            n_bad++; $display("FAIL busy_coincident: got %0d issues want 0", hits);
        end
        nd = 3'b100;
        step();
        nd = 3'b000;
        step();
        n_cmp++;
        if ({new_note, note_out[17:12]} !== {3'b100, 6'd32}) begin
            n_bad++; $display("FAIL busy_third: got nn=%b note=%0d want 100/32", new_note, note_out[17:12]);
        end
    endtask

    task automatic test_pause();
        int moved;
        do_reset(); clear_rom();
        rom[0] = ent(1, 0, 0, 3);
        song = 2'd0; play = 1'b1;
        step(); step(); step();
        pulse_beat();
        play = 1'b0;
        moved = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_beat();
            if (rom_addr !== 7'd0) moved++;
        end
        n_cmp++;
        if (moved != 0) begin
            n_bad++; $display("FAIL pause_frozen: got %0d moves want 0", moved);
        end
        play = 1'b1;
        pulse_beat();
        n_cmp++;
        if (rom_addr !== 7'd0) begin
            n_bad++; $display("FAIL pause_resume_one: got %0d want 0", rom_addr);
        end
        pulse_beat();
        n_cmp++;
        if (rom_addr !== 7'd1) begin
            n_bad++; $display("FAIL pause_resume_two: got %0d want 1", rom_addr);
        end
    endtask

    task automatic test_song_switch();
        do_reset(); clear_rom();
        rom[0]  = ent(0, 0, 10, 3);
        rom[1]  = ent(1, 0, 0, 5);
        rom[64] = ent(0, 0, 40, 1);
        rom[65] = ent(0, 1, 41, 2);
        song = 2'd0; play = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (rom_addr !== 7'd1) begin
            n_bad++; $display("FAIL switch_pre: got %0d want 1", rom_addr);
        end
        song = 2'd2;
        step();
        n_cmp++;
        if ({rom_addr, new_note, song_done} !== {7'd64, 3'b000, 1'b0}) begin
            n_bad++;
            $display("FAIL switch_addr: got addr=%0d nn=%b sd=%b want 64/000/0", rom_addr, new_note, song_done);
        end
        step(); step();
        n_cmp++;
        if ({new_note, note_out[5:0]} !== {3'b001, 6'd40}) begin
            n_bad++; $display("FAIL switch_v0: got nn=%b note=%0d want 001/40", new_note, note_out[5:0]);
        end
        step(); step();
        n_cmp++;
        if ({new_note, note_out[11:6]} !== {3'b010, 6'd41}) begin
            n_bad++; $display("FAIL switch_v1: got nn=%b note=%0d want 010/41", new_note, note_out[11:6]);
        end
        step();
        n_cmp++;
        if (song_done !== 1'b0) begin
            n_bad++; $display("FAIL switch_no_done: got %b want 0", song_done);
        end
        step();
        n_cmp++;
        if (song_done !== 1'b1) begin
            n_bad++; $display("FAIL switch_done: got %b want 1", song_done);
        end
    endtask

    task automatic test_wrap();
        int nn, sd;
        do_reset(); clear_rom();
        for (int i = 0; i < 32; i++) rom[32 + i] = ent(0, 3, i, i);
        song = 2'd1; play = 1'b1;
        nn = 0; sd = 0;
        for (int e = 1; e <= 64; e++) begin
            step();
            if (new_note !== 3'b000) nn++;
            if (song_done !== 1'b0) sd++;
        end
        n_cmp++;
        if (sd != 0) begin
            n_bad++; $display("FAIL wrap_early_done: got %0d pulses want 0", sd);
        end
        step();
        n_cmp++;
        if ({song_done, rom_addr} !== {1'b1, 7'd63}) begin
            n_bad++; $display("FAIL wrap_done: got sd=%b addr=%0d want 1/63", song_done, rom_addr);
        end
        sd = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (new_note !== 3'b000) nn++;
            if (song_done !== 1'b0 || rom_addr !== 7'd63) sd++;
        end
        n_cmp++;
        if (nn != 0) begin
            n_bad++; $display("FAIL wrap_invalid_voice: got %0d issues want 0", nn);
        end
        n_cmp++;
        if (sd != 0) begin
            n_bad++; $display("FAIL wrap_hold: got %0d bad cycles want 0", sd);
        end
        play = 1'b0;
        step(); step();
        n_cmp++;
        if ({rom_addr, song_done} !== {7'd32, 1'b0}) begin
            n_bad++; $display("FAIL wrap_idle: got addr=%0d sd=%b want 32/0", rom_addr, song_done);
        end
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; beat = 1'b0; nd = '0; song = '0;
        clear_rom();
        step();
        test_reset();
        test_basic();
        test_busy_stall();
        test_pause();
        test_song_switch();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
